router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of stored entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter WIDTH, default 8, data byte width; each stored entry SHALL be WIDTH+1 bits (byte plus header flag).
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 soft_reset  input  1  synchronous, active-high flush, driven by the synchronizer on read timeout.
REQ-006 write_enb  input  1  write request.
REQ-007 lfd_state  input  1  high when data_in is a packet header byte.
REQ-008 data_in  input  WIDTH  write byte.
REQ-009 read_enb  input  1  read request from the destination side.
REQ-010 data_out  output  WIDTH  registered read byte.
REQ-011 full  output  1  no free entry.
REQ-012 empty  output  1  no stored entry; vld_out upstream equals ~empty.
REQ-013 pkt_end  output  1  one-cycle pulse when the final byte (parity) of a packet is presented on data_out.

Function
REQ-014 Write accepted when write_enb && !full; stores {lfd_state, data_in} at wr_ptr, then wr_ptr increments.
REQ-015 Read accepted when read_enb && !empty; data_out loads the stored byte on that edge (1-cycle latency), rd_ptr increments.
REQ-016 write_enb while full SHALL be dropped with no state change; read_enb while empty SHALL be ignored, data_out held.
REQ-017 Simultaneous accepted read and write SHALL both occur; occupancy unchanged; full/empty unchanged.
REQ-018 Simultaneous read and write while empty: write occurs, read ignored; empty deasserts next cycle.
REQ-019 Simultaneous read and write while full: read occurs, write dropped; full deasserts next cycle.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits; wrap from DEPTH-1 to 0 with MSB toggle; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-021 full and empty SHALL be registered-pointer derived, reflecting the state after the current edge.
REQ-022 Packet counter (6 bits): on read of a header-flagged entry, load data[7:2] + 1 (payload length plus parity).
REQ-023 On read of a non-header entry with counter nonzero, decrement; when decrement reaches 0, pkt_end SHALL pulse high the same cycle data_out carries that byte.
REQ-024 Header read with counter nonzero (truncated packet) SHALL reload the counter; no pkt_end for the abandoned packet.
REQ-025 Header with length field 0 SHALL load count 1; next non-header read asserts pkt_end.
REQ-026 Counter saturates at 0; non-header reads with count 0 SHALL NOT pulse pkt_end.

Reset
REQ-027 reset or soft_reset high at an edge SHALL clear both pointers, packet counter, data_out to 0, pkt_end to 0; empty=1, full=0 next cycle.
REQ-028 reset/soft_reset SHALL override any write/read in the same cycle; storage array contents need not be cleared.
REQ-029 Both asserted together SHALL behave identically to either alone.

Structure
REQ-030 Shared package router_pkg SHALL hold DEPTH/WIDTH defaults, header-length field position (bits 7:2) and the 9-bit entry typedef.
REQ-031 Single module; no sub-modules; storage is an inferred register array.

Verification
REQ-032 Reset: assert reset 2 cycles mid-write burst -> empty=1, full=0, data_out=8'h00, pkt_end=0.
REQ-033 Fill: write 16 bytes 8'h01..8'h10, no reads -> full=1 after 16th edge; 17th write 8'hFF dropped; 16 reads return 01..10 in order, then empty=1.
REQ-034 Packet: header 8'h0C (len 3, lfd_state=1), payload AA,BB,CC, parity 5D; read all -> pkt_end high only with data_out=8'h5D.
REQ-035 Concurrency: at occupancy 16 assert read and write (8'h77) -> read occurs, write dropped, full=0; at occupancy 0 both -> 8'h77 stored, empty=0.
REQ-036 Soft reset: 5 bytes stored, soft_reset 1 cycle with read_enb high -> empty=1, data_out=8'h00, subsequent writes start at entry 0.
REQ-037 Wrap: 40 streaming write/read pairs with 1-cycle-lagged reads -> output sequence equals input, no false full/empty.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router FIFO: default sizes, header length
// field position and the stored entry layout (header flag plus data byte).
package router_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int WIDTH_DEFAULT = 8;

  // Payload length lives in bits 7:2 of a header byte
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;

  // Packet byte counter width matches the length field
  localparam int CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // One stored entry: header flag in the top bit, data byte below
  typedef struct packed {
    logic                     hdr;
    logic [WIDTH_DEFAULT-1:0] data;
  } entry_t;

endpackage

// File: rtl/router_fifo.sv
// Router output FIFO: stores bytes tagged with a header flag, presents them
// on a registered output, and tracks packet length so that pkt_end pulses
// alongside the final (parity) byte of each packet.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_end
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pkt_end_q, pkt_end_d;

  logic             flush;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH:0]   rd_entry;

  // Either reset source flushes the FIFO and overrides traffic that cycle
  assign flush     = reset | soft_reset;

  // Extra pointer MSB distinguishes a full ring from an empty one
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);

  assign wr_accept = write_enb && !full && !flush;
  assign rd_accept = read_enb && !empty && !flush;
  assign rd_entry  = mem_q[rd_ptr_q[AW-1:0]];

  assign data_out  = data_out_q;
  assign pkt_end   = pkt_end_q;

  // Next-state for pointers, output byte and packet length tracking
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    pkt_end_d  = 1'b0;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = rd_entry[WIDTH-1:0];
      if (rd_entry[WIDTH]) begin
        // A header always restarts the count, abandoning any unfinished packet
        cnt_d = rd_entry[HDR_LEN_MSB:HDR_LEN_LSB] + CNT_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d     = cnt_q - CNT_W'(1);
        pkt_end_d = (cnt_q == CNT_W'(1));
      end
    end
  end

  // Register update with synchronous flush
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
      pkt_end_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      pkt_end_q  <= pkt_end_d;
    end
  end

  // Storage array; contents are left alone on flush since pointers gate access
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, fill/drain, packet
// end detection, concurrent access at the boundaries, soft reset and wrap.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_end;

  int checks   = 0;
  int failures = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .pkt_end   (pkt_end)
  );

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single write cycle
  task automatic push(input logic hdr, input logic [7:0] b);
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = b;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  // Single read cycle
  task automatic pop();
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
  endtask

  // Read one entry and check the byte and packet-end flag it comes with
  task automatic pop_check(input string tag, input logic [7:0] exp_data,
                           input logic exp_end);
    pop();
    check_output({tag, "_data"}, {24'h0, data_out}, {24'h0, exp_data});
    check_output({tag, "_end"}, {31'h0, pkt_end}, {31'h0, exp_end});
  endtask

  initial begin
    logic [7:0] pkt_bytes [5];
    logic [7:0] pkt_ends  [5];
    logic [7:0] trunc_b   [6];
    logic       trunc_h   [6];
    logic       trunc_e   [6];

    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;

    // Power-on reset
    tick();
    tick();
    check_output("por_empty", {31'h0, empty}, 32'h1);
    check_output("por_full", {31'h0, full}, 32'h0);
    check_output("por_data", {24'h0, data_out}, 32'h0);
    check_output("por_end", {31'h0, pkt_end}, 32'h0);
    reset = 1'b0;

    // Reset held two cycles in the middle of a write burst
    push(1'b0, 8'hA1);
    push(1'b0, 8'hA2);
    check_output("burst_notempty", {31'h0, empty}, 32'h0);
    write_enb = 1'b1;
    data_in   = 8'hA3;
    reset     = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
    write_enb = 1'b0;
    check_output("rst_empty", {31'h0, empty}, 32'h1);
    check_output("rst_full", {31'h0, full}, 32'h0);
    check_output("rst_data", {24'h0, data_out}, 32'h0);
    check_output("rst_end", {31'h0, pkt_end}, 32'h0);

    // Fill with 01..10; full only after the 16th write
    for (int i = 1; i <= 16; i++) begin
      push(1'b0, 8'(i));
      if (i == 15) check_output("fill15_full", {31'h0, full}, 32'h0);
    end
    check_output("fill16_full", {31'h0, full}, 32'h1);
    push(1'b0, 8'hFF);
    check_output("drop_full", {31'h0, full}, 32'h1);
    for (int i = 1; i <= 16; i++) begin
      pop_check($sformatf("drain%0d", i), 8'(i), 1'b0);
      if (i == 1) check_output("drain1_full", {31'h0, full}, 32'h0);
    end
    check_output("drain_empty", {31'h0, empty}, 32'h1);
    // Read while empty is ignored and the output byte is held
    pop();
    check_output("idle_read_data", {24'h0, data_out}, 32'h10);
    check_output("idle_read_empty", {31'h0, empty}, 32'h1);

    // Packet: header len 3, three payload bytes, parity
    pkt_bytes = '{8'h0C, 8'hAA, 8'hBB, 8'hCC, 8'h5D};
    pkt_ends  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 5; i++) push(i == 0, pkt_bytes[i]);
    for (int i = 0; i < 5; i++)
      pop_check($sformatf("pkt%0d", i), pkt_bytes[i], pkt_ends[i][0]);
    tick();
    check_output("pkt_end_oneshot", {31'h0, pkt_end}, 32'h0);

    // Header with zero length: next payload byte ends the packet
    push(1'b1, 8'h00);
    push(1'b0, 8'h11);
    push(1'b0, 8'h12);
    pop_check("len0_hdr", 8'h00, 1'b0);
    pop_check("len0_par", 8'h11, 1'b1);
    pop_check("len0_after", 8'h12, 1'b0);

    // Truncated packet: second header reloads the count
    trunc_b = '{8'h08, 8'h31, 8'h08, 8'h41, 8'h42, 8'h43};
    trunc_h = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    trunc_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) push(trunc_h[i], trunc_b[i]);
    for (int i = 0; i < 6; i++)
      pop_check($sformatf("trunc%0d", i), trunc_b[i], trunc_e[i]);

    // Concurrent read and write while full: write dropped
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h20 + i));
    check_output("conc_full", {31'h0, full}, 32'h1);
    read_enb  = 1'b1;
    write_enb = 1'b1;
    data_in   = 8'h77;
    tick();
    read_enb  = 1'b0;
    write_enb = 1'b0;
    check_output("conc_full_data", {24'h0, data_out}, 32'h20);
    check_output("conc_full_flag", {31'h0, full}, 32'h0);
    for (int i = 1; i < 16; i++) pop();
    check_output("conc_last", {24'h0, data_out}, 32'h2F);
    check_output("conc_drained", {31'h0, empty}, 32'h1);

    // Concurrent read and write while empty: write stored, read ignored
    read_enb  = 1'b1;
    write_enb = 1'b1;
    data_in   = 8'h77;
    tick();
    read_enb  = 1'b0;
    write_enb = 1'b0;
    check_output("conc_empty_flag", {31'h0, empty}, 32'h0);
    check_output("conc_empty_hold", {24'h0, data_out}, 32'h2F);
    pop_check("conc_empty_rd", 8'h77, 1'b0);
    check_output("conc_empty_after", {31'h0, empty}, 32'h1);

    // Soft reset with a read pending flushes everything
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h51 + i));
    soft_reset = 1'b1;
    read_enb   = 1'b1;
    tick();
    soft_reset = 1'b0;
    read_enb   = 1'b0;
    check_output("soft_empty", {31'h0, empty}, 32'h1);
    check_output("soft_data", {24'h0, data_out}, 32'h0);
    check_output("soft_end", {31'h0, pkt_end}, 32'h0);
    push(1'b0, 8'h61);
    push(1'b0, 8'h62);
    pop_check("soft_rd0", 8'h61, 1'b0);
    pop_check("soft_rd1", 8'h62, 1'b0);
    check_output("soft_after", {31'h0, empty}, 32'h1);

    // Streaming with one-cycle-lagged reads across several pointer wraps
    for (int k = 0; k < 40; k++) begin
      write_enb = 1'b1;
      data_in   = 8'(k * 7 + 3);
      read_enb  = (k != 0);
      tick();
      if (k != 0)
        check_output($sformatf("wrap%0d_data", k), {24'h0, data_out},
                     32'((k - 1) * 7 + 3) & 32'hFF);
      check_output($sformatf("wrap%0d_empty", k), {31'h0, empty}, 32'h0);
      check_output($sformatf("wrap%0d_full", k), {31'h0, full}, 32'h0);
    end
    write_enb = 1'b0;
    pop_check("wrap_last", 8'(39 * 7 + 3), 1'b0);
    check_output("wrap_empty", {31'h0, empty}, 32'h1);

    // Both reset sources together behave like either alone
    push(1'b0, 8'h91);
    push(1'b0, 8'h92);
    pop();
    reset      = 1'b1;
    soft_reset = 1'b1;
    write_enb  = 1'b1;
    read_enb   = 1'b1;
    data_in    = 8'h93;
    tick();
    reset      = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    check_output("both_empty", {31'h0, empty}, 32'h1);
    check_output("both_data", {24'h0, data_out}, 32'h0);
    check_output("both_full", {31'h0, full}, 32'h0);

    $display("[TB] directed sequence complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
